hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage core. It is the complement of the operand-forwarding logic: it stalls and flushes the pipeline wherever forwarding cannot resolve a hazard.
- Covers load-use stalls, taken-branch flushes in EX, and data-memory wait states using a req/ready handshake.
- Drives the pipeline-register enables and flushes. Exposes saturating performance counters and a sticky memory-timeout flag.

Parameters:
- regAddress_w, 5, register-file address width.
- CNT_W, 32, width of the performance counters.
- MEM_TIMEOUT, 64, MEM_WAIT cycles before mem_timeout is set (must be at least 1).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- id_rs1  in  regAddress_w  rs1 of the instruction in ID.
- id_rs2  in  regAddress_w  rs2 of the instruction in ID.
- id_use_rs1  in  1  ID instruction reads rs1.
- id_use_rs2  in  1  ID instruction reads rs2.
- ex_mem_read  in  1  EX instruction is a load.
- ex_reg_write  in  1  EX instruction writes rd.
- ex_rd  in  regAddress_w  rd of the EX instruction.
- ex_branch_taken  in  1  branch/jump resolved taken in EX.
- mem_req  in  1  MEM instruction is accessing data memory.
- dmem_ready  in  1  data memory completes this cycle.
- pc_en  out  1  PC update enable.
- if_id_en  out  1  IF/ID register enable.
- id_ex_en  out  1  ID/EX register enable.
- ex_mem_en  out  1  EX/MEM register enable.
- mem_wb_en  out  1  MEM/WB register enable.
- if_id_flush  out  1  clear IF/ID to a NOP.
- id_ex_flush  out  1  clear ID/EX to a NOP (bubble).
- mem_wb_bubble  out  1  load a NOP into MEM/WB.
- stall_cycles  out  CNT_W  number of cycles with pc_en=0 after S_INIT.
- flush_count  out  CNT_W  number of branch flushes.
- mem_timeout  out  1  sticky: a memory wait exceeded MEM_TIMEOUT.

Behaviour:
- FSM states: S_INIT, S_RUN, S_MEM_WAIT.
  - Reset (asynchronous) enters S_INIT, sets counters to 0, clears mem_timeout and the wait counter.
  - Reset asserted mid-operation aborts any wait immediately with no pending state retained.
- S_INIT (exactly one cycle after rst_n deasserts):
  - All enables 0; if_id_flush=1, id_ex_flush=1, mem_wb_bubble=1.
  - Next state is S_RUN unconditionally.
- While rst_n is low, outputs equal the S_INIT values.
- Hazard conditions, evaluated combinationally:
  - lu (load-use) = ex_mem_read & ex_reg_write & (ex_rd!=0) & ((id_use_rs1 & ex_rd==id_rs1) | (id_use_rs2 & ex_rd==id_rs2)).
  - mw (memory wait) = mem_req & !dmem_ready.
- S_RUN, priority mw > ex_branch_taken > lu > normal:
  - mw: pc, if_id, id_ex and ex_mem enables 0; mem_wb_bubble=1. Go to S_MEM_WAIT and load wait counter = 1.
  - Branch taken: all enables 1; if_id_flush=1, id_ex_flush=1. flush_count += 1. The branch overrides lu because the ID instruction is squashed.
  - lu: pc_en=0, if_id_en=0, id_ex_flush=1; ex_mem_en=1, mem_wb_en=1. Exactly 1 stall cycle, because the next cycle the load is in MEM and is forwarded.
  - Normal: all enables 1; no flush.
- S_MEM_WAIT:
  - Outputs are the same as the S_RUN mw case while mem_req & !dmem_ready.
  - dmem_ready=1: that cycle, all enables 1 and no bubble; go to S_RUN.
  - Wait counter saturates at MEM_TIMEOUT. When it reaches MEM_TIMEOUT, set mem_timeout (sticky until reset). Keep waiting; never abandon the access.
  - mem_req dropping to 0 while waiting is illegal. Return to S_RUN; do not set any flag.
  - ex_branch_taken and lu are ignored in S_MEM_WAIT. They re-evaluate in S_RUN because the frozen stages still hold them.
- Counters:
  - stall_cycles increments in every cycle where pc_en=0 and state != S_INIT.
  - Both counters saturate at all-ones and never wrap.
- Output timing: enable and flush outputs are combinational from state and inputs (0 latency). Counters and the flag are registered and update at the next edge.
- Rule: the x0 destination never causes a stall.

Decomposition:
- hazard_pkg:
  - state_t enum {S_INIT, S_RUN, S_MEM_WAIT}.
  - Default regAddress_w.
  - A NOP-control struct (the enables and flushes as one packed struct).
- One sub-module, sat_counter (parameter W; inputs inc, clk, rst_n; output count), instanced twice.

Test Plan:
- Reset released at cycle 0 -> cycle 0: all enables 0, flushes 1 -> cycle 1: all enables 1; counters = 0.
- ex_mem_read=1, ex_reg_write=1, ex_rd=5, id_rs2=5, id_use_rs2=1 for one cycle -> pc_en=0, if_id_en=0, id_ex_flush=1 that cycle; stall_cycles=1. Same stimulus with ex_rd=0 -> no stall.
- ex_branch_taken=1 together with an lu condition -> flushes asserted, pc_en=1, no stall; flush_count=1.
- mem_req=1 with dmem_ready low for 3 cycles, then high -> 3 cycles of ex_mem_en=0 and mem_wb_bubble=1, then the release cycle has all enables 1; stall_cycles=3; state returns to S_RUN.
- MEM_TIMEOUT=4, dmem_ready low for 10 cycles -> mem_timeout goes high after the 4th wait cycle and stays high after ready arrives, until rst_n pulses.
- rst_n pulsed low mid-S_MEM_WAIT -> outputs take the S_INIT values immediately (asynchronously); counters and flag return to 0; one S_INIT cycle, then S_RUN.

Source files
------------

// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and control encodings for the pipeline hazard controller
package hazard_pkg;

   localparam int REG_ADDR_W = 5;

   typedef enum logic [1:0] {
      S_INIT,
      S_RUN,
      S_MEM_WAIT
   } state_t;

   typedef struct packed {
      logic pc_en;
      logic if_id_en;
      logic id_ex_en;
      logic ex_mem_en;
      logic mem_wb_en;
      logic if_id_flush;
      logic id_ex_flush;
      logic mem_wb_bubble;
   } ctrl_t;

   // Field order: pc, if_id, id_ex, ex_mem, mem_wb enables, then if_id/id_ex flush, mem_wb bubble.
   localparam ctrl_t CTRL_INIT     = 8'b00000_111;
   localparam ctrl_t CTRL_RUN      = 8'b11111_000;
   localparam ctrl_t CTRL_BRANCH   = 8'b11111_110;
   localparam ctrl_t CTRL_LOAD_USE = 8'b00111_010;
   localparam ctrl_t CTRL_MEM_HOLD = 8'b00001_001;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - up-counter that sticks at all-ones instead of wrapping
module sat_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inc,
   output logic [W-1:0] count
);

   logic [W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (inc && (count_q != '1)) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - stall/flush control for hazards the forwarding network cannot resolve
module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int regAddress_w = REG_ADDR_W,
   parameter int CNT_W        = 32,
   parameter int MEM_TIMEOUT  = 64
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [regAddress_w-1:0] id_rs1,
   input  logic [regAddress_w-1:0] id_rs2,
   input  logic                    id_use_rs1,
   input  logic                    id_use_rs2,
   input  logic                    ex_mem_read,
   input  logic                    ex_reg_write,
   input  logic [regAddress_w-1:0] ex_rd,
   input  logic                    ex_branch_taken,
   input  logic                    mem_req,
   input  logic                    dmem_ready,
   output logic                    pc_en,
   output logic                    if_id_en,
   output logic                    id_ex_en,
   output logic                    ex_mem_en,
   output logic                    mem_wb_en,
   output logic                    if_id_flush,
   output logic                    id_ex_flush,
   output logic                    mem_wb_bubble,
   output logic [CNT_W-1:0]        stall_cycles,
   output logic [CNT_W-1:0]        flush_count,
   output logic                    mem_timeout
);

   localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
   localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

   state_t            state_q, state_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic              timeout_q, timeout_d;
   logic              lu, mw;
   logic              flush_inc, stall_inc;
   ctrl_t             ctrl;

   // A load into x0 never produces a value, so it can never be a load-use source.
   assign lu = ex_mem_read && ex_reg_write && (ex_rd != '0) &&
               ((id_use_rs1 && (ex_rd == id_rs1)) || (id_use_rs2 && (ex_rd == id_rs2)));
   assign mw = mem_req && !dmem_ready;

   always_comb begin
      state_d   = state_q;
      wait_d    = wait_q;
      ctrl      = CTRL_INIT;
      flush_inc = 1'b0;
      case (state_q)
         S_INIT: begin
            state_d = S_RUN;
         end
         S_RUN: begin
            if (mw) begin
               ctrl    = CTRL_MEM_HOLD;
               state_d = S_MEM_WAIT;
               wait_d  = WAIT_W'(1);
            end else if (ex_branch_taken) begin
               ctrl      = CTRL_BRANCH;
               flush_inc = 1'b1;
            end else if (lu) begin
               ctrl = CTRL_LOAD_USE;
            end else begin
               ctrl = CTRL_RUN;
            end
         end
         S_MEM_WAIT: begin
            // Branch and load-use are held frozen in EX/ID and get re-examined once back in S_RUN.
            if (mw) begin
               ctrl = CTRL_MEM_HOLD;
               if (wait_q != WAIT_MAX) begin
                  wait_d = wait_q + 1'b1;
               end
            end else begin
               ctrl    = CTRL_RUN;
               state_d = S_RUN;
               wait_d  = '0;
            end
         end
         default: begin
            state_d = S_INIT;
         end
      endcase
   end

   assign timeout_d = timeout_q || (wait_d == WAIT_MAX);
   assign stall_inc = (state_q != S_INIT) && !ctrl.pc_en;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_INIT;
         wait_q    <= '0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         wait_q    <= wait_d;
         timeout_q <= timeout_d;
      end
   end

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (stall_inc),
      .count (stall_cycles)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (flush_inc),
      .count (flush_count)
   );

   assign pc_en         = ctrl.pc_en;
   assign if_id_en      = ctrl.if_id_en;
   assign id_ex_en      = ctrl.id_ex_en;
   assign ex_mem_en     = ctrl.ex_mem_en;
   assign mem_wb_en     = ctrl.mem_wb_en;
   assign if_id_flush   = ctrl.if_id_flush;
   assign id_ex_flush   = ctrl.id_ex_flush;
   assign mem_wb_bubble = ctrl.mem_wb_bubble;
   assign mem_timeout   = timeout_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed bench with a cycle-level reference model of the hazard controller
module tb_hazard_ctrl;

   localparam int AW   = 5;
   localparam int CW   = 4;
   localparam int TMO  = 4;
   localparam int CMAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [AW-1:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
   logic          id_use_rs1 = 1'b0, id_use_rs2 = 1'b0;
   logic          ex_mem_read = 1'b0, ex_reg_write = 1'b0, ex_branch_taken = 1'b0;
   logic          mem_req = 1'b0, dmem_ready = 1'b0;
   logic          pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
   logic          if_id_flush, id_ex_flush, mem_wb_bubble, mem_timeout;
   logic [CW-1:0] stall_cycles, flush_count;

   int n_tests = 0;
   int n_fail  = 0;

   hazard_ctrl #(.regAddress_w(AW), .CNT_W(CW), .MEM_TIMEOUT(TMO)) dut (
      .clk(clk), .rst_n(rst_n),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
      .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write), .ex_rd(ex_rd),
      .ex_branch_taken(ex_branch_taken), .mem_req(mem_req), .dmem_ready(dmem_ready),
      .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en),
      .mem_wb_en(mem_wb_en), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
      .mem_wb_bubble(mem_wb_bubble), .stall_cycles(stall_cycles), .flush_count(flush_count),
      .mem_timeout(mem_timeout)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: pipeline mode flags plus plain integer counters.
   bit m_init = 1'b1, m_wait = 1'b0, m_tmo = 1'b0;
   int m_len = 0, m_stall = 0, m_flush = 0;
   bit n_init = 1'b1, n_wait = 1'b0, n_tmo = 1'b0;
   int n_len = 0, n_stall = 0, n_flush = 0;
   logic [7:0] exp_v, act_v;
   bit lu_c, mw_c;

   always @(negedge clk) begin
      lu_c = ex_mem_read && ex_reg_write && (ex_rd != 0) &&
             ((id_use_rs1 && ex_rd == id_rs1) || (id_use_rs2 && ex_rd == id_rs2));
      mw_c = mem_req && !dmem_ready;
      if (!rst_n || m_init)      exp_v = 8'b00000_111;
      else if (mw_c)             exp_v = 8'b00001_001;
      else if (m_wait)           exp_v = 8'b11111_000;
      else if (ex_branch_taken)  exp_v = 8'b11111_110;
      else if (lu_c)             exp_v = 8'b00111_010;
      else                       exp_v = 8'b11111_000;
      act_v = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush, mem_wb_bubble};
      chk("ctrl_vector", 32'(act_v), 32'(exp_v));
      chk("stall_cycles", 32'(stall_cycles), m_stall);
      chk("flush_count", 32'(flush_count), m_flush);
      chk("mem_timeout", 32'(mem_timeout), 32'(m_tmo));

      n_init  = 1'b0;
      n_stall = m_stall + ((!m_init && !exp_v[7]) ? 1 : 0);
      if (n_stall > CMAX) n_stall = CMAX;
      n_flush = m_flush + ((!m_init && !m_wait && !mw_c && ex_branch_taken) ? 1 : 0);
      if (n_flush > CMAX) n_flush = CMAX;
      if (!m_init && mw_c) begin
         n_wait = 1'b1;
         n_len  = m_wait ? ((m_len < TMO) ? m_len + 1 : TMO) : 1;
      end else begin
         n_wait = 1'b0;
         n_len  = 0;
      end
      n_tmo = m_tmo || (n_len == TMO);
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_init <= 1'b1; m_wait <= 1'b0; m_tmo <= 1'b0;
         m_len <= 0; m_stall <= 0; m_flush <= 0;
      end else begin
         m_init <= n_init; m_wait <= n_wait; m_tmo <= n_tmo;
         m_len <= n_len; m_stall <= n_stall; m_flush <= n_flush;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
      id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
      ex_mem_read = 1'b0; ex_reg_write = 1'b0; ex_branch_taken = 1'b0;
      mem_req = 1'b0; dmem_ready = 1'b0;
   endtask

   task automatic load_use(input logic [AW-1:0] rd);
      ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_rd = rd;
      id_rs2 = rd; id_use_rs2 = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      idle();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("init_pc_en", 32'(pc_en), 0);
      chk("init_if_id_flush", 32'(if_id_flush), 1);
      chk("init_bubble", 32'(mem_wb_bubble), 1);
      tick(); @(negedge clk);
      chk("run_pc_en", 32'(pc_en), 1);
      chk("run_mem_wb_en", 32'(mem_wb_en), 1);
      chk("run_stall0", 32'(stall_cycles), 0);

      tick(); load_use(5'd5); @(negedge clk);
      chk("lu_pc_en", 32'(pc_en), 0);
      chk("lu_if_id_en", 32'(if_id_en), 0);
      chk("lu_id_ex_flush", 32'(id_ex_flush), 1);
      chk("lu_ex_mem_en", 32'(ex_mem_en), 1);
      tick(); idle(); @(negedge clk);
      chk("lu_stall1", 32'(stall_cycles), 1);

      tick(); load_use(5'd0); @(negedge clk);
      chk("x0_pc_en", 32'(pc_en), 1);
      tick(); load_use(5'd5); id_use_rs2 = 1'b0; id_use_rs1 = 1'b1; id_rs1 = 5'd3; @(negedge clk);
      chk("unused_rs2_pc_en", 32'(pc_en), 1);
      tick(); idle(); ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_rd = 5'd7;
      id_rs1 = 5'd7; id_use_rs1 = 1'b1; @(negedge clk);
      chk("lu_rs1_pc_en", 32'(pc_en), 0);

      tick(); idle(); load_use(5'd5); ex_branch_taken = 1'b1; @(negedge clk);
      chk("br_pc_en", 32'(pc_en), 1);
      chk("br_if_id_flush", 32'(if_id_flush), 1);
      chk("br_id_ex_flush", 32'(id_ex_flush), 1);
      tick(); idle(); @(negedge clk);
      chk("br_flush_count", 32'(flush_count), 1);
      chk("br_stall2", 32'(stall_cycles), 2);

      tick(); mem_req = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("mw_ex_mem_en", 32'(ex_mem_en), 0);
         chk("mw_bubble", 32'(mem_wb_bubble), 1);
         tick();
      end
      dmem_ready = 1'b1; @(negedge clk);
      chk("mw_release_pc_en", 32'(pc_en), 1);
      chk("mw_release_ex_mem_en", 32'(ex_mem_en), 1);
      chk("mw_release_bubble", 32'(mem_wb_bubble), 0);
      tick(); idle(); load_use(5'd9); @(negedge clk);
      chk("mw_stall5", 32'(stall_cycles), 5);
      chk("mw_no_timeout", 32'(mem_timeout), 0);
      chk("after_mw_lu_pc_en", 32'(pc_en), 0);

      tick(); idle(); mem_req = 1'b1;
      for (int w = 1; w <= 10; w++) begin
         @(negedge clk);
         if (w == 4) chk("tmo_before", 32'(mem_timeout), 0);
         if (w == 5) chk("tmo_set", 32'(mem_timeout), 1);
         tick();
         ex_branch_taken = (w == 5 || w == 6);
      end
      ex_branch_taken = 1'b0; dmem_ready = 1'b1; @(negedge clk);
      chk("tmo_release_pc_en", 32'(pc_en), 1);
      tick(); idle(); @(negedge clk);
      chk("tmo_sticky", 32'(mem_timeout), 1);
      chk("stall_saturated", 32'(stall_cycles), 15);
      chk("wait_ignores_branch", 32'(flush_count), 1);

      tick(); mem_req = 1'b1;
      tick(); tick(); mem_req = 1'b0; @(negedge clk);
      chk("drop_pc_en", 32'(pc_en), 1);
      tick(); load_use(5'd4); @(negedge clk);
      chk("drop_then_lu", 32'(pc_en), 0);

      tick(); idle(); mem_req = 1'b1;
      tick(); tick();
      @(negedge clk); #2 rst_n = 1'b0; #1;
      chk("arst_pc_en", 32'(pc_en), 0);
      chk("arst_ex_mem_en", 32'(ex_mem_en), 0);
      chk("arst_id_ex_flush", 32'(id_ex_flush), 1);
      chk("arst_bubble", 32'(mem_wb_bubble), 1);
      chk("arst_stall", 32'(stall_cycles), 0);
      chk("arst_flush", 32'(flush_count), 0);
      chk("arst_tmo", 32'(mem_timeout), 0);
      @(posedge clk); #1 rst_n = 1'b1; @(negedge clk);
      chk("arst_init_pc_en", 32'(pc_en), 0);
      chk("arst_init_if_id_flush", 32'(if_id_flush), 1);
      tick(); @(negedge clk);
      chk("arst_run_mw_ex_mem_en", 32'(ex_mem_en), 0);
      chk("arst_run_mw_bubble", 32'(mem_wb_bubble), 1);
      tick(); dmem_ready = 1'b1; @(negedge clk);
      chk("arst_release_pc_en", 32'(pc_en), 1);
      tick(); idle(); @(negedge clk);
      chk("arst_stall1", 32'(stall_cycles), 1);

      repeat (2) tick();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
